// File: rtl/if_id_buffer_if.sv
// if_id_buffer_if: fetch-side and decode-side handshake bundle for the IF/ID queue.
interface if_id_buffer_if #(parameter int PTR_W = 1);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [31:0]      out_pc8;
  logic             out_is_beq;
  logic             out_is_j;
  logic             out_is_jal;
  logic             out_is_jr;
  logic [PTR_W:0]   count;
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc8,
           out_is_beq, out_is_j, out_is_jal, out_is_jr, count
  );
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc8,
           out_is_beq, out_is_j, out_is_jal, out_is_jr, count
  );
endinterface

// File: rtl/if_id_buffer.sv
// if_id_buffer: FWFT fetch-to-decode queue with flush and head predecode.
// Optional IFID_STALL_CNT_EN adds a stall_cycles counter port.
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter int          PTR_W    = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset,
  if_id_buffer_if.slave bus
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [31:0]  stall_cycles
`endif
);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic             push, pop;
  logic [31:0]      head;
  logic [5:0]       opcode;
  assign bus.in_ready  = count_q < FULL;
  assign bus.out_valid = count_q != '0;
  assign bus.count     = count_q;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  // Empty queue masks stale storage so decode sees a nop at RESET_PC.
  assign head           = bus.out_valid ? instr_q[rd_ptr_q] : 32'h0;
  assign opcode         = head[31:26];
  assign bus.out_instr  = head;
  assign bus.out_pc     = bus.out_valid ? pc_q[rd_ptr_q] : RESET_PC;
  assign bus.out_pc8    = bus.out_pc + 32'd8;
  assign bus.out_is_beq = bus.out_valid && opcode == 6'b000100;
  assign bus.out_is_j   = bus.out_valid && opcode == 6'b000010;
  assign bus.out_is_jal = bus.out_valid && opcode == 6'b000011;
  assign bus.out_is_jr  = bus.out_valid && opcode == 6'b000000 && head[5:0] == 6'b001000;
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = push && !pop ? count_q + 1'b1 :
                 pop && !push ? count_q - 1'b1 : count_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      instr_q[wr_ptr_q] <= bus.in_instr;
      pc_q[wr_ptr_q]    <= bus.in_pc;
    end
  end
`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d      = bus.out_valid && !bus.out_ready && !bus.flush ? stall_q + 32'd1 : stall_q;
  assign stall_cycles = stall_q;
  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
endmodule
